rd_modport: RTL and testbench



---
 rtl/rd_fifo_pkg.sv | 19 +
 rtl/rd_fifo_mem.sv | 36 +++
 rtl/rd_modport.sv | 77 +++++++
 tb/tb_rd_modport.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/rd_fifo_pkg.sv
// Shared sizing and pointer type for the single-clock read-domain FIFO.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
package rd_fifo_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0]   ptr_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    localparam ptr_t FULL_LEVEL = ptr_t'(DEPTH);

    function automatic addr_t ptr_addr(input ptr_t p);
        return p[ADDR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/rd_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, registered read with enable (1 cycle).
// No flow control here; the caller guarantees read and write never target the same live slot.
module rd_fifo_mem
    import rd_fifo_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_wr_en,
    input  addr_t i_wr_addr,
    input  data_t i_wr_data,
    input  logic  i_rd_en,
    input  addr_t i_rd_addr,
    output data_t o_rd_data
);

    data_t r_mem [DEPTH];
    data_t r_rd_data;

    // Storage is deliberately not reset; only the output register is.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rd_modport.sv
// 32-entry single-clock FIFO exposing the async FIFO read-domain port set; read data 1 cycle after accept.
// Rejected writes (full) and reads (empty) are dropped and flagged with one-cycle overflow/underflow pulses.
module rd_modport
    import rd_fifo_pkg::*;
(
    input  logic                  rclk,
    input  logic                  sw_rst,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  wfull,
    output logic                  overflow,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] aempty_value,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  rdempty,
    output logic                  rd_almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   fifo_read_count,
    output logic [ADDR_WIDTH:0]   rd_level
);

    ptr_t r_wptr;
    ptr_t r_rptr;
    logic r_overflow;
    logic r_underflow;

    ptr_t w_level;
    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Acceptance uses only pre-edge pointers, so a read on empty never sees a same-cycle write.
    assign w_level  = r_wptr - r_rptr;
    assign w_full   = (w_level == FULL_LEVEL);
    assign w_empty  = (w_level == '0);
    assign w_wr_acc = write_enable && !w_full;
    assign w_rd_acc = read_enable && !w_empty;

    always_ff @(posedge rclk) begin
        if (sw_rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + ptr_t'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + ptr_t'(1);
            end
            r_overflow  <= write_enable && w_full;
            r_underflow <= read_enable && w_empty;
        end
    end

    rd_fifo_mem u_mem (
        .i_clk     (rclk),
        .i_rst     (sw_rst),
        .i_wr_en   (w_wr_acc && !sw_rst),
        .i_wr_addr (ptr_addr(r_wptr)),
        .i_wr_data (write_data),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (ptr_addr(r_rptr)),
        .o_rd_data (read_data)
    );

    assign wfull           = w_full;
    assign overflow        = r_overflow;
    assign underflow       = r_underflow;
    assign rdempty         = w_empty;
    assign rd_level        = w_level;
    assign fifo_read_count = r_rptr;
    assign rd_almost_empty = (w_level <= {1'b0, aempty_value});

endmodule

// File: tb/tb_rd_modport.sv
// Bench for rd_modport: a queue model of the FIFO feeds an expected-read-data scoreboard.
module tb_rd_modport;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          rclk = 1'b0;
    logic          sw_rst = 1'b0;
    logic          write_enable = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          wfull;
    logic          overflow;
    logic          read_enable = 1'b0;
    logic [AW-1:0] aempty_value = '0;
    logic [DW-1:0] read_data;
    logic          rdempty;
    logic          rd_almost_empty;
    logic          underflow;
    logic [AW:0]   fifo_read_count;
    logic [AW:0]   rd_level;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] m_fifo [$];
    logic [DW-1:0] exp_rd_q [$];
    logic [DW-1:0] m_last_rd = '0;
    int            m_rptr = 0;
    bit            m_wrapped = 0;

    always #5 rclk = ~rclk;

    rd_modport dut (
        .rclk            (rclk),
        .sw_rst          (sw_rst),
        .write_enable    (write_enable),
        .write_data      (write_data),
        .wfull           (wfull),
        .overflow        (overflow),
        .read_enable     (read_enable),
        .aempty_value    (aempty_value),
        .read_data       (read_data),
        .rdempty         (rdempty),
        .rd_almost_empty (rd_almost_empty),
        .underflow       (underflow),
        .fifo_read_count (fifo_read_count),
        .rd_level        (rd_level)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_flags(input bit exp_udf, input bit exp_ovf);
        chk("underflow", 64'(underflow), 64'(exp_udf));
        chk("overflow",  64'(overflow),  64'(exp_ovf));
        chk("rd_level",  64'(rd_level),  64'(m_fifo.size()));
        chk("rdempty",   64'(rdempty),   64'(m_fifo.size() == 0));
        chk("wfull",     64'(wfull),     64'(m_fifo.size() == 32));
        chk("aempty",    64'(rd_almost_empty), 64'(m_fifo.size() <= int'(aempty_value)));
        chk("rd_count",  64'(fifo_read_count), 64'(m_rptr));
    endtask

    // One cycle: drive one step after the edge, check one step after the next edge.
    task automatic op(input bit wr, input logic [DW-1:0] wdat, input bit rd);
        bit wr_ok, rd_ok;
        wr_ok = wr && (m_fifo.size() < 32);
        rd_ok = rd && (m_fifo.size() > 0);
        if (rd_ok) begin
            exp_rd_q.push_back(m_fifo.pop_front());
            m_rptr = (m_rptr + 1) % 64;
            if (m_rptr == 0) m_wrapped = 1;
        end
        if (wr_ok) m_fifo.push_back(wdat);
        write_enable = wr;
        write_data   = wdat;
        read_enable  = rd;
        @(posedge rclk);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        if (rd_ok) begin
            m_last_rd = exp_rd_q.pop_front();
            chk("read_data", 64'(read_data), 64'(m_last_rd));
        end else begin
            chk("read_hold", 64'(read_data), 64'(m_last_rd));
        end
        chk_flags(rd && !rd_ok, wr && !wr_ok);
    endtask

    task automatic do_reset(input bit busy);
        sw_rst       = 1'b1;
        write_enable = busy;
        read_enable  = busy;
        write_data   = 32'hDEAD_BEEF;
        @(posedge rclk);
        #1;
        sw_rst       = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        m_fifo.delete();
        exp_rd_q.delete();
        m_last_rd = '0;
        m_rptr    = 0;
        chk("rst_read_data", 64'(read_data), 64'd0);
        chk_flags(1'b0, 1'b0);
    endtask

    initial begin
        @(posedge rclk);
        #1;
        do_reset(1'b0);
        op(0, '0, 0);

        // Basic ordering
        for (int i = 0; i < 4; i++) op(1, 32'hA0 + i, 0);
        for (int i = 0; i < 4; i++) op(0, '0, 1);
        chk("count_after_4", 64'(fifo_read_count), 64'd4);

        // Almost-empty threshold
        aempty_value = 5'd3;
        for (int i = 0; i < 3; i++) op(1, 32'hB0 + i, 0);
        chk("aempty_at_3", 64'(rd_almost_empty), 64'd1);
        op(1, 32'hB3, 0);
        chk("aempty_at_4", 64'(rd_almost_empty), 64'd0);
        for (int i = 0; i < 4; i++) op(0, '0, 1);

        // Underflow, back-to-back underflow, and read+write on empty
        op(0, '0, 1);
        op(0, '0, 1);
        op(1, 32'hC0, 1);
        chk("udf_rw_level", 64'(rd_level), 64'd1);
        op(0, '0, 1);

        // Fill, overflow, full read+write, wraparound pairs
        aempty_value = '0;
        for (int i = 0; i < 32; i++) op(1, 32'hD000 + i, 0);
        chk("full_level", 64'(rd_level), 64'd32);
        op(1, 32'hDEAD, 0);
        op(1, 32'hDEAE, 1);
        chk("full_rw_level", 64'(rd_level), 64'd31);
        for (int i = 0; i < 40; i++) op(1, 32'hE000 + i, 1);
        while (m_fifo.size() > 0) op(0, '0, 1);
        chk("ptr_wrapped", 64'(m_wrapped), 64'd1);

        // Random mix
        for (int i = 0; i < 300; i++) begin
            aempty_value = AW'($urandom_range(0, 31));
            op(bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)));
        end

        // Reset with data stored and requests pending
        while (m_fifo.size() > 0) op(0, '0, 1);
        for (int i = 0; i < 10; i++) op(1, 32'hF0 + i, 0);
        op(0, '0, 1);
        do_reset(1'b1);
        chk("rst_level", 64'(rd_level), 64'd0);
        op(0, '0, 1);
        chk("post_rst_udf", 64'(underflow), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
